serial_subtractor11: RTL and testbench

//  Bit-serial two's-complement subtractor: computes diff = a - b one bit per clock

---
 rtl/serial_subtractor11.sv | 125 ++++++++++++
 tb/tb_serial_subtractor11.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor11.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first,
// using a single full-subtractor cell fed from operand shift registers.
// A start/done handshake lets a controller issue back-to-back operations.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous, active-high reset
//   start_i   request; sampled only in idle or done
//   a_i       minuend, unsigned; captured on accepted start
//   b_i       subtrahend, unsigned; captured on accepted start
//   busy_o    high while bits are being computed
//   done_o    one-cycle pulse; diff_o/borrow_o valid
//   diff_o    a - b, two's complement, Width+1 bits; diff_o[Width] is the sign
//   borrow_o  1 iff a < b (final borrow-out)
module serial_subtractor11 #(
  parameter int unsigned Width = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width:0]   diff_o,
  output logic             borrow_o
);

  localparam int unsigned CntW = $clog2(Width);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [Width-1:0]  a_sr_q, a_sr_d;
  logic [Width-1:0]  b_sr_q, b_sr_d;
  logic [Width-1:0]  res_q, res_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              bin_q, bin_d;
  logic [Width:0]    diff_q, diff_d;
  logic              borrow_q, borrow_d;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  logic             a_bit, b_bit, axb, d_bit, bout;
  logic [Width-1:0] res_shift;
  logic             last_bit;

  assign a_bit = a_sr_q[0];
  assign b_bit = b_sr_q[0];
  assign axb   = a_bit ^ b_bit;
  assign d_bit = axb ^ bin_q;
  assign bout  = (~a_bit & b_bit) | (~axb & bin_q);

  // Result bits enter at the MSB so after Width shifts bit 0 sits at res[0].
  assign res_shift = {d_bit, res_q[Width-1:1]};
  assign last_bit  = (cnt_q == CntW'(Width - 1));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          a_sr_d  = a_i;
          b_sr_d  = b_i;
          cnt_d   = '0;
          bin_d   = 1'b0;
          state_d = StBusy;
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = res_shift;
        bin_d  = bout;
        if (last_bit) begin
          // Counter parks at zero rather than wrapping past Width-1.
          cnt_d    = '0;
          diff_d   = {bout, res_shift};
          borrow_d = bout;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy_o   = (state_q == StBusy);
  assign done_o   = (state_q == StDone);
  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;

endmodule

// File: tb/tb_serial_subtractor11.sv
// Directed and random bench for serial_subtractor11 with an expected-result queue.
module tb_serial_subtractor11;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W:0]   diff;
  logic         borrow;

  int n_vec = 0;
  int n_err = 0;

  // {borrow, diff}
  logic [W+1:0] exp_q[$];
  logic [W:0]   last_diff;
  logic         last_borrow;

  serial_subtractor11 #(.Width(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .diff_o  (diff),
    .borrow_o(borrow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    return {(x < y), d};
  endfunction

  // Drive a one-cycle start; returns at the first falling edge of the busy phase.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic compare_out(input string tag);
    logic [W+1:0] e;
    check({tag, "_queue"}, exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_diff"}, diff, e[W:0]);
      check({tag, "_borrow"}, borrow, e[W+1]);
      last_diff   = e[W:0];
      last_borrow = e[W+1];
    end
  endtask

  // Bounded wait for done; n counts falling edges waited, bcnt counts busy samples.
  task automatic wait_done(input string tag, output int n, output int bcnt);
    n = 0;
    bcnt = 0;
    while (!done && n < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      n++;
    end
    if (!done) check({tag, "_timeout"}, done, 1);
    else compare_out(tag);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    int n, bcnt;
    issue(x, y);
    wait_done(tag, n, bcnt);
    // Start sampled one edge before the first wait, so 11 waits = 12 cycles start-to-done.
    check({tag, "_latency"}, n, W);
    check({tag, "_busycycles"}, bcnt, W);
    @(negedge clk);
    check({tag, "_donewidth"}, done, 0);
    check({tag, "_idlebusy"}, busy, 0);
    check({tag, "_holddiff"}, diff, last_diff);
    check({tag, "_holdborrow"}, borrow, last_borrow);
  endtask

  initial begin
    int n, bcnt, t1, t2, consec, ndone;
    logic prev_done;
    logic [W-1:0] rx, ry;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_borrow", borrow, 0);
    rst = 1'b0;

    run_op("t1_5m3", 11'd5, 11'd3);
    run_op("t2_3m5", 11'd3, 11'd5);
    run_op("t3_max_m0", 11'h7FF, 11'd0);
    run_op("t3_0_mmax", 11'd0, 11'h7FF);
    run_op("eq", 11'd1234, 11'd1234);

    // Back-to-back with start held high through DONE.
    @(negedge clk);
    a = 11'd9;
    b = 11'd9;
    start = 1'b1;
    exp_q.push_back(model(11'd9, 11'd9));
    t1 = -1;
    t2 = -1;
    consec = 0;
    prev_done = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        if (prev_done) consec++;
        compare_out("t4_b2b");
        if (t1 < 0) begin
          t1 = c;
          exp_q.push_back(model(11'd1, 11'd2));
        end else begin
          t2 = c;
        end
      end
      prev_done = done;
      if (c == 1) begin
        a = 11'd1;
        b = 11'd2;
      end
      if (c == 13) start = 1'b0;
    end
    check("t4_first_done", t1, 12);
    check("t4_gap", t2 - t1, 12);
    check("t4_width", consec, 0);

    // Start pulsed mid-BUSY with different operands must be ignored.
    issue(11'd20, 11'd7);
    repeat (3) @(negedge clk);
    a = 11'd1;
    b = 11'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 11'd0;
    b = 11'h7FF;
    wait_done("t5_ignore", n, bcnt);
    check("t5_latency", n, 7);
    @(negedge clk);
    check("t5_donewidth", done, 0);

    // Reset while bit 5 is about to be processed.
    issue(11'd100, 11'd50);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_diff", diff, 0);
    check("t6_borrow", borrow, 0);
    rst = 1'b0;
    exp_q.delete();
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t6_no_done", ndone, 0);
    run_op("t6_restart", 11'd100, 11'd50);
    check("t6_restart_val", diff, 12'h032);

    for (int i = 0; i < 3000; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      run_op($sformatf("rand%0d", i), rx, ry);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
